test_modes_param: RTL

//  Parametrised successor benchmark exercising every mode of the k8 logic block: LUT logic,
//  a registered WIDTH-bit ripple adder, and a tapped FF shift chain, plus a chain fill counter.
//  Top-level benchmark; all I/O maps straight to pads. Stresses carry chain, FF packing, LUT+FF modes.

---
 rtl/test_modes_pkg.sv | 25 ++
 rtl/tm_shift_chain.sv | 53 +++++
 rtl/test_modes_param.sv | 81 ++++++++
 3 files changed

// File: rtl/test_modes_pkg.sv
// Shared defaults and elaboration-time helpers for the test_modes benchmark.
package test_modes_pkg;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_NUM_TAPS   = 3;
  localparam int DEF_TAP_STRIDE = 4;

  // Chain stage observed by tap j.
  function automatic int tap_index(input int j, input int stride);
    return (j + 1) * stride - 1;
  endfunction

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tm_shift_chain.sv
// Enabled FF shift chain with periodic taps and a saturating fill counter.
module tm_shift_chain
  import test_modes_pkg::*;
#(
  parameter int DEPTH      = DEF_NUM_TAPS * DEF_TAP_STRIDE,
  parameter int NUM_TAPS   = DEF_NUM_TAPS,
  parameter int TAP_STRIDE = DEF_TAP_STRIDE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                d0,
  input  logic                shift_en,
  output logic [NUM_TAPS-1:0] taps,
  output logic                chain_full
);

  localparam int CW = clog2(DEPTH + 1);

  logic [DEPTH-1:0] stages;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;

  always_comb begin
    // NOTE: assign the default first so this block can never infer a latch.
    count_nxt = count;
    if (shift_en && (count != CW'(DEPTH)))
      count_nxt = count + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the stages are an ordinary register chain, not a RAM, so they take
      // the reset too; this is what discards in-flight data on a mid-stream reset.
      stages     <= '0;
      count      <= '0;
      chain_full <= 1'b0;
    end else begin
      if (shift_en) begin
        stages[0] <= d0;
        for (int i = 1; i < DEPTH; i++)
          stages[i] <= stages[i-1];
      end
      count      <= count_nxt;
      chain_full <= (count_nxt == CW'(DEPTH));
    end
  end

  for (genvar j = 0; j < NUM_TAPS; j++) begin : g_tap
    localparam int IDX = tap_index(j, TAP_STRIDE);
    assign taps[j] = stages[IDX];
  end

endmodule

// File: rtl/test_modes_param.sv
// Logic-block mode benchmark: LUT source, registered ripple adder, tapped shift chain.
// Define TEST_MODES_ACCUM_EN to add the acc_en port and accumulate mode (sum fed back as B).
module test_modes_param
  import test_modes_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int NUM_TAPS   = DEF_NUM_TAPS,
  parameter int TAP_STRIDE = DEF_TAP_STRIDE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                cin,
  input  logic                e,
  input  logic                f,
  input  logic                g,
  input  logic                shift_en,
`ifdef TEST_MODES_ACCUM_EN
  input  logic                acc_en,
`endif
  output logic [WIDTH-1:0]    sum,
  output logic                cout,
  output logic [NUM_TAPS-1:0] taps,
  output logic                chain_full
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [WIDTH-1:0] op_b;
  logic             d0;
`ifdef TEST_MODES_ACCUM_EN
  logic             acc_q;
`endif

  always_comb begin
    op_b = b_q;
`ifdef TEST_MODES_ACCUM_EN
    if (acc_q)
      op_b = sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
`ifdef TEST_MODES_ACCUM_EN
      acc_q       <= 1'b0;
`endif
      {cout, sum} <= '0;
    end else begin
      a_q         <= a;
      b_q         <= b;
      cin_q       <= cin;
`ifdef TEST_MODES_ACCUM_EN
      acc_q       <= acc_en;
`endif
      // Carry-out is the MSB of the WIDTH+1-bit sum; wrap is natural.
      {cout, sum} <= {1'b0, a_q} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin_q};
    end
  end

  assign d0 = (e & g) | ~f;

  tm_shift_chain #(
    .DEPTH      (NUM_TAPS * TAP_STRIDE),
    .NUM_TAPS   (NUM_TAPS),
    .TAP_STRIDE (TAP_STRIDE)
  ) u_chain (
    .clk        (clk),
    .rst        (rst),
    .d0         (d0),
    .shift_en   (shift_en),
    .taps       (taps),
    .chain_full (chain_full)
  );

endmodule
